// File: rtl/lfsr.sv
// Fibonacci shift-left LFSR with a per-load shift counter.
// The seed is reloaded every cycle that the block is idle or in reset.
module lfsr #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk_96MHz,
  input  logic             reset,
  input  logic [WIDTH-1:0] polynomial,
  input  logic [WIDTH-1:0] start_data,
  input  logic             enable,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] iteration_number
);

  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             feedback;

  // The polynomial is used live, so a tap change lands on the very next shift.
  always_comb begin
    feedback = ^(value_q & polynomial);
    value_d  = {value_q[WIDTH-2:0], feedback};
    count_d  = count_q + 1'b1;
  end

  always_ff @(posedge clk_96MHz) begin
    if (reset || !enable) begin
      value_q <= start_data;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

  assign value            = value_q;
  assign iteration_number = count_q;

endmodule

// File: tb/tb_lfsr.sv
// Bench for lfsr: a 17-bit instance for the main sequences and an 8-bit instance
// so counter wrap and full-period behaviour fit in a short run.
module tb_lfsr;

  localparam int unsigned W  = 17;
  localparam int unsigned SW = 8;

  logic          clk;
  logic          reset, enable;
  logic [W-1:0]  polynomial, start_data, value, iteration_number;
  logic          s_reset, s_enable;
  logic [SW-1:0] s_polynomial, s_start_data, s_value, s_iteration_number;

  int checks = 0;
  int errors = 0;

  // Reference state, kept as plain integers masked to the instance width.
  logic [31:0] m_val, m_cnt, s_mval, s_mcnt;

  lfsr #(.WIDTH(W)) dut (
    .clk_96MHz       (clk),
    .reset           (reset),
    .polynomial      (polynomial),
    .start_data      (start_data),
    .enable          (enable),
    .value           (value),
    .iteration_number(iteration_number)
  );

  lfsr #(.WIDTH(SW)) dut_small (
    .clk_96MHz       (clk),
    .reset           (s_reset),
    .polynomial      (s_polynomial),
    .start_data      (s_start_data),
    .enable          (s_enable),
    .value           (s_value),
    .iteration_number(s_iteration_number)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] wmask(int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Shift left by one, new LSB is the parity of the tapped bits, MSB falls off.
  function automatic logic [31:0] lfsr_next(logic [31:0] v, logic [31:0] p, int unsigned w);
    logic fb;
    fb = ^(v & p & wmask(w));
    return ((v << 1) | {31'd0, fb}) & wmask(w);
  endfunction

  function automatic int first_repeat(logic [31:0] seed, logic [31:0] p, int unsigned w);
    logic [31:0] v;
    v = seed;
    for (int i = 1; i <= (1 << w); i++) begin
      v = lfsr_next(v, p, w);
      if (v == seed) return i;
    end
    return 0;
  endfunction

  // Advance both models from the inputs currently applied, then clock.
  task automatic step();
    if (reset || !enable) begin
      m_val = 32'(start_data);
      m_cnt = 0;
    end else begin
      m_val = lfsr_next(m_val, 32'(polynomial), W);
      m_cnt = (m_cnt + 1) & wmask(W);
    end
    if (s_reset || !s_enable) begin
      s_mval = 32'(s_start_data);
      s_mcnt = 0;
    end else begin
      s_mval = lfsr_next(s_mval, 32'(s_polynomial), SW);
      s_mcnt = (s_mcnt + 1) & wmask(SW);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    polynomial = 17'h1D258; start_data = 17'h0_5A5A;
    step();
    checks++;
    if (value !== 17'h0_5A5A || iteration_number !== 17'd0) begin
      errors++;
      $display("FAIL reset_priority: value=%h count=%h, required value=05a5a count=0",
               value, iteration_number);
    end
  endtask

  task automatic test_sequence();
    logic [W-1:0] exp_v [5];
    exp_v[0] = 17'h00002; exp_v[1] = 17'h00004; exp_v[2] = 17'h00008;
    exp_v[3] = 17'h00011; exp_v[4] = 17'h00023;
    reset = 1'b1; enable = 1'b1; polynomial = 17'h1D258; start_data = 17'h00001;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (value !== exp_v[i] || iteration_number !== 17'(i + 1)) begin
        errors++;
        $display("FAIL sequence[%0d]: value=%h count=%0d, required value=%h count=%0d",
                 i, value, iteration_number, exp_v[i], i + 1);
      end
    end
  endtask

  task automatic test_idle_hold();
    reset = 1'b0; enable = 1'b0; start_data = 17'h00ABC;
    for (int i = 0; i < 10; i++) begin
      polynomial = 17'($urandom);
      step();
      checks++;
      if (value !== 17'h00ABC || iteration_number !== 17'd0) begin
        errors++;
        $display("FAIL idle_hold[%0d]: value=%h count=%0d, required value=00abc count=0",
                 i, value, iteration_number);
      end
    end
  endtask

  task automatic test_long_run();
    reset = 1'b0; enable = 1'b0; polynomial = 17'h1D258; start_data = 17'h00001;
    step();
    enable = 1'b1;
    for (int i = 0; i < 7500; i++) begin
      start_data = 17'($urandom); // must not disturb a running sequence
      step();
      checks++;
      if (value !== m_val[W-1:0] || iteration_number !== m_cnt[W-1:0]) begin
        errors++;
        $display("FAIL long_run[%0d]: value=%h count=%0d, required value=%h count=%0d",
                 i, value, iteration_number, m_val[W-1:0], m_cnt);
      end
    end
    checks++;
    if (iteration_number !== 17'h01D4C) begin
      errors++;
      $display("FAIL long_run_count: count=%h, required 01d4c", iteration_number);
    end
  endtask

  task automatic test_mid_run_abort(input bit use_reset);
    reset = 1'b1; enable = 1'b1; polynomial = 17'h1D258; start_data = 17'h00001;
    step();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) step();
    if (use_reset) reset = 1'b1;
    else           enable = 1'b0;
    step();
    checks++;
    if (value !== 17'h00001 || iteration_number !== 17'd0) begin
      errors++;
      $display("FAIL abort_load(reset=%0d): value=%h count=%0d, required value=00001 count=0",
               use_reset, value, iteration_number);
    end
    reset = 1'b0; enable = 1'b1;
    step();
    checks++;
    if (value !== 17'h00002 || iteration_number !== 17'd1) begin
      errors++;
      $display("FAIL abort_restart(reset=%0d): value=%h count=%0d, required value=00002 count=1",
               use_reset, value, iteration_number);
    end
  endtask

  task automatic test_random_mix();
    reset = 1'b1; step();
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 31) == 0);
      enable     = ($urandom_range(0, 15) != 0);
      start_data = 17'($urandom);
      if ($urandom_range(0, 7) == 0) polynomial = 17'($urandom);
      step();
      checks++;
      if (value !== m_val[W-1:0] || iteration_number !== m_cnt[W-1:0]) begin
        errors++;
        $display("FAIL random_mix[%0d]: value=%h count=%0d, required value=%h count=%0d",
                 i, value, iteration_number, m_val[W-1:0], m_cnt);
      end
    end
  endtask

  task automatic test_lockup();
    reset = 1'b0; enable = 1'b0; polynomial = 17'h1D258; start_data = 17'd0;
    step();
    enable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if (value !== 17'd0 || iteration_number !== 17'(i)) begin
        errors++;
        $display("FAIL lockup[%0d]: value=%h count=%0d, required value=0 count=%0d",
                 i, value, iteration_number, i);
      end
    end
  endtask

  task automatic test_zero_poly();
    reset = 1'b0; enable = 1'b0; polynomial = 17'd0; start_data = 17'h1FFFF;
    step();
    enable = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      step();
      checks++;
      if (value !== 17'((32'h1FFFF << i) & 32'h1FFFF)) begin
        errors++;
        $display("FAIL zero_poly[%0d]: value=%h, required %h",
                 i, value, 17'((32'h1FFFF << i) & 32'h1FFFF));
      end
    end
  endtask

  task automatic test_wrap();
    s_reset = 1'b1; s_enable = 1'b1; s_polynomial = 8'hB8; s_start_data = 8'h01;
    step();
    s_reset = 1'b0;
    for (int i = 1; i <= (1 << SW) + 3; i++) begin
      step();
      checks++;
      if (s_iteration_number !== SW'(i % (1 << SW)) || s_value !== s_mval[SW-1:0]) begin
        errors++;
        $display("FAIL wrap[%0d]: count=%0d value=%h, required count=%0d value=%h",
                 i, s_iteration_number, s_value, i % (1 << SW), s_mval[SW-1:0]);
      end
    end
  endtask

  task automatic test_period();
    int exp_p, got_p;
    exp_p = first_repeat(32'h01, 32'hB8, SW);
    s_reset = 1'b1; s_enable = 1'b1; s_polynomial = 8'hB8; s_start_data = 8'h01;
    step();
    s_reset = 1'b0;
    got_p = 0;
    for (int i = 1; i <= (1 << SW) + 8 && got_p == 0; i++) begin
      step();
      if (s_value === 8'h01) got_p = int'(s_iteration_number);
    end
    $display("period: first repeat of seed at iteration %0d (reference %0d)", got_p, exp_p);
    checks++;
    if (got_p != exp_p) begin
      errors++;
      $display("FAIL period: first repeat=%0d, required %0d", got_p, exp_p);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; polynomial = '0; start_data = '0;
    s_reset = 1'b1; s_enable = 1'b0; s_polynomial = '0; s_start_data = '0;
    m_val = 0; m_cnt = 0; s_mval = 0; s_mcnt = 0;
    test_reset();
    test_sequence();
    test_idle_hold();
    test_long_run();
    test_mid_run_abort(1'b1);
    test_mid_run_abort(1'b0);
    test_random_mix();
    test_lockup();
    test_zero_poly();
    test_wrap();
    test_period();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr.md
LFSR -- requirements
Module: lfsr

Interface
REQ-001: Parameter WIDTH, default 17, sets the register, polynomial, seed and counter width in bits; all widths below are WIDTH.
REQ-002: clk_96MHz  input  1  single system clock; all state updates on its rising edge.
REQ-003: reset  input  1  reset, synchronous and active-high.
REQ-004: polynomial  input  17  feedback tap mask; bit i set means state bit i feeds the parity.
REQ-005: start_data  input  17  seed loaded into the register while idle or in reset.
REQ-006: enable  input  1  high = step one shift per clock; low = hold in load state.
REQ-007: value  output  17  current LFSR state, registered.
REQ-008: iteration_number  output  17  number of shifts since the last load, registered.

Function
REQ-009: The LFSR SHALL be Fibonacci, shift-left: feedback = XOR-reduction of (value AND polynomial), and next value = {value[15:0], feedback}.
REQ-010: The MSB shifted out SHALL be discarded, and value SHALL always be exactly 17 bits.
REQ-011: With enable high and reset low, each rising edge SHALL apply one shift and increment iteration_number by 1.
REQ-012: Outputs SHALL have a latency of 1 clock: the first shifted value appears on the edge after enable is first sampled high.
REQ-013: With enable low and reset low, each edge SHALL load value <= start_data and iteration_number <= 0.
REQ-014: Deasserting enable mid-run SHALL discard progress.
REQ-015: Reasserting enable SHALL restart from the current start_data with count 0.
REQ-016: iteration_number SHALL wrap modulo 2^17 (0x1FFFF -> 0x00000) with no flag or saturation.
REQ-017: polynomial and start_data SHALL be sampled every cycle and are not latched.
REQ-018: Changing polynomial while enabled SHALL take effect on the next shift.
REQ-019: Changing start_data while enabled SHALL have no effect until the next load.
REQ-020: There SHALL be no lock-up protection: if value is 0 while enabled, it stays 0 while iteration_number keeps counting.
REQ-021: If polynomial is 0, the feedback SHALL be 0, so the state shifts toward zero.
REQ-022: The block SHALL contain no combinational path from any input to value or iteration_number.

Reset
REQ-023: On a rising edge with reset high, the block SHALL set value <= start_data and iteration_number <= 0, regardless of enable.
REQ-024: Reset SHALL take priority over enable.
REQ-025: Reset asserted mid-run SHALL abort the sequence on that edge.
REQ-026: After reset deasserts with enable high, shifting SHALL begin on the next edge.
REQ-027: Outputs are undefined before the first clock edge; no other state exists.

Verification
REQ-028: Sequence check: reset, then polynomial=0x1D258, start_data=0x00001, enable=1 for 5 cycles -> value = 0x00002, 0x00004, 0x00008, 0x00011, 0x00023, with iteration_number = 1..5.
REQ-029: Idle hold: enable=0 for 10 cycles with start_data=0x00ABC -> value=0x00ABC and iteration_number=0 every cycle.
REQ-030: Long run: enable=1 for 7500 cycles after the load -> iteration_number=7500 (0x01D4C), and value matches a software model of REQ-009/REQ-010 at every cycle.
REQ-031: Mid-run abort: pulse reset (or drop enable) for 1 cycle after 100 shifts -> value=start_data, iteration_number=0, then the sequence restarts from 0x00002.
REQ-032: Wrap: run 131072 cycles -> iteration_number rolls over to 0 without any glitch.
REQ-033: Period: with polynomial=0x1D258, value returns to 0x00001 at iteration 131071 only if the polynomial is maximal; the bench reports the first-repeat iteration.
REQ-034: Lock-up: start_data=0, enable=1 -> value stays 0 while iteration_number counts.
